// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID front-end sequencing controller.
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   // Encoding of addi x0, x0, 0. The IF/ID register loads this word on a flush.
   localparam logic [31:0] NOP_INSN = 32'h00000013;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an IF/ID source register that matches a load's destination in ID/EX.
module load_use_detect #(
   parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] ifid_rs1,
   input  logic [REG_ADDR_W-1:0] ifid_rs2,
   input  logic                  ifid_uses_rs2,
   input  logic                  idex_mem_read,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   output logic                  load_use
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use = idex_mem_read && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID and PC sequencing for load-use stalls, taken branches and variable-latency fetch.
// Optional performance counters are built when IFID_HAZARD_PERF_EN is defined.
//
// state   | meaning
// BOOT    | first cycle after reset, all enables low
// FETCH   | normal fetch; stalls, flushes and fetch waits are decided here
// DISCARD | waiting out a fetch issued before a taken branch; its data is dropped
module ifid_hazard_ctrl #(
   parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
`ifdef IFID_HAZARD_PERF_EN
   ,
   parameter int PERF_W = 32
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] ifid_rs1,
   input  logic [REG_ADDR_W-1:0] ifid_rs2,
   input  logic                  ifid_uses_rs2,
   input  logic                  idex_mem_read,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic                  branch_taken,
   input  logic                  imem_ready,
   output logic                  imem_req,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  exmem_flush,
`ifdef IFID_HAZARD_PERF_EN
   output logic [PERF_W-1:0]     stall_cycles,
   output logic [PERF_W-1:0]     flush_events,
   output logic [PERF_W-1:0]     fetch_wait_cycles,
`endif
   output logic [1:0]            ctrl_state
);

   import pipe_ctrl_pkg::*;

   ctrl_state_t state;
   logic        load_use;

   load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
      .ifid_rs1      (ifid_rs1),
      .ifid_rs2      (ifid_rs2),
      .ifid_uses_rs2 (ifid_uses_rs2),
      .idex_mem_read (idex_mem_read),
      .idex_rd       (idex_rd),
      .load_use      (load_use)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
      end else begin
         case (state)
            BOOT:    state <= FETCH;
            FETCH:   if (branch_taken && !imem_ready) state <= DISCARD;
            DISCARD: if (imem_ready) state <= FETCH;
            default: state <= BOOT;
         endcase
      end
   end

   // Enables are combinational from state and inputs so a hazard acts in the cycle it appears.
   always_comb begin
      imem_req    = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (branch_taken) begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end else if (load_use) begin
               idex_flush = 1'b1;
            end else if (!imem_ready) begin
               ifid_write = 1'b1;
               ifid_flush = 1'b1;
            end else begin
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         end
         DISCARD: begin
            // PC already holds the branch target; only the stale fetch is drained.
            imem_req   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
         end
         default: ;
      endcase
   end

   assign ctrl_state = state;

`ifdef IFID_HAZARD_PERF_EN
   logic stall_evt, flush_evt, wait_evt;

   assign stall_evt = (state == FETCH) && !branch_taken && load_use;
   assign flush_evt = (state == FETCH) && branch_taken;
   assign wait_evt  = imem_req && !imem_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles      <= '0;
         flush_events      <= '0;
         fetch_wait_cycles <= '0;
      end else begin
         if (stall_evt && (stall_cycles != '1))
            stall_cycles <= stall_cycles + PERF_W'(1);
         if (flush_evt && (flush_events != '1))
            flush_events <= flush_events + PERF_W'(1);
         if (wait_evt && (fetch_wait_cycles != '1))
            fetch_wait_cycles <= fetch_wait_cycles + PERF_W'(1);
      end
   end
`endif

endmodule

// File: doc/ifid_hazard_ctrl.md
Name: ifid_hazard_ctrl

Overview:
- Front-end sequencing controller for the IF/ID pipeline register and the PC.
- Generates PC write enable, IF/ID write/flush, and ID/EX and EX/MEM flush.
- Handles three events: load-use hazards, taken branches resolved in EX/MEM, and a variable-latency instruction-memory req/ready handshake.
- Sits beside the IF/ID register and drives the enables and synchronous-clear inputs the team adds to the pipeline registers.

Parameters:
- REG_ADDR_W, 5, register index width.
- PERF_W, 32, performance counter width (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifid_rs1  in  REG_ADDR_W  rs1 field of the instruction in IF/ID.
- ifid_rs2  in  REG_ADDR_W  rs2 field of the instruction in IF/ID.
- ifid_uses_rs2  in  1  instruction in IF/ID reads rs2.
- idex_mem_read  in  1  instruction in ID/EX is a load.
- idex_rd  in  REG_ADDR_W  destination register in ID/EX.
- branch_taken  in  1  taken branch/jump resolved in EX/MEM; one-cycle pulse.
- imem_ready  in  1  instruction memory returns data this cycle; may be high in the same cycle as imem_req.
- imem_req  out  1  fetch request at the current PC.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP; effective only with ifid_write=1.
- idex_flush  out  1  ID/EX loads a bubble.
- exmem_flush  out  1  EX/MEM loads a bubble.
- ctrl_state  out  2  FSM state for debug: BOOT=0, FETCH=1, DISCARD=2.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to BOOT.
  - All outputs are 0 except ctrl_state=0.
- FSM:
  - BOOT -> FETCH unconditionally on the first clock after reset deasserts. BOOT drives all outputs 0.
  - FETCH -> DISCARD when branch_taken=1 and imem_ready=0. Otherwise FETCH stays in FETCH.
  - DISCARD -> FETCH when imem_ready=1.
- load_use (combinational): idex_mem_read && idex_rd!=0 && (idex_rd==ifid_rs1 || (ifid_uses_rs2 && idex_rd==ifid_rs2)).
- FETCH outputs: imem_req=1. Priority is highest first:
  1. branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1. The fetched word is dropped.
  2. load_use: pc_write=0, ifid_write=0, idex_flush=1. IF/ID holds. This holds regardless of imem_ready.
  3. imem_ready=0: pc_write=0, ifid_write=1, ifid_flush=1. A NOP enters IF/ID and older instructions drain.
  4. Otherwise: pc_write=1, ifid_write=1, all flushes 0.
- DISCARD outputs:
  - imem_req=1; the stale request is held until the memory completes.
  - pc_write=0, because the PC already holds the branch target.
  - ifid_write=1, ifid_flush=1.
  - A branch_taken in DISCARD is ignored; it cannot occur because the EX/MEM stage holds only bubbles.
  - On imem_ready the data is dropped and the state returns to FETCH.
- Latency: zero-cycle combinational from inputs to enables. A load-use stall lasts exactly one cycle, because the bubble in ID/EX clears idex_mem_read.
- Boundary conditions:
  - idex_rd=0 never stalls.
  - branch_taken together with load_use: branch wins, no stall.
  - branch_taken together with imem_ready=1: no DISCARD state.
  - Reset mid-DISCARD: returns to BOOT; the outstanding request is abandoned.

Optional Feature:
- Macro: IFID_HAZARD_PERF_EN.
- When defined: adds outputs stall_cycles, flush_events and fetch_wait_cycles, each PERF_W bits.
  - They count load_use stall cycles, branch_taken events, and cycles with imem_req=1 and imem_ready=0, respectively.
  - Counters saturate at all-ones and clear on reset.
- When undefined: the ports and the logic are absent.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - The state enum: BOOT, FETCH, DISCARD.
  - REG_ADDR_W.
  - The NOP encoding 32'h00000013, used by the IF/ID register on flush.
- One natural sub-module: load_use_detect, the combinational comparator.

Test Plan:
- Reset released with imem_ready=1 and no hazards -> cycle 1: ctrl_state=0, outputs 0. Cycle 2+: pc_write=ifid_write=1, flushes 0.
- idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1. Same stimulus with idex_rd=0 -> no stall.
- imem_ready low for 3 cycles -> 3 cycles with pc_write=0, ifid_write=1, ifid_flush=1, then normal advance.
- branch_taken pulse while imem_ready=0, ready returns 2 cycles later -> branch cycle: all three flushes=1, pc_write=1. Then 2 DISCARD cycles (ctrl_state=2, pc_write=0, ifid_flush=1), then back to FETCH.
- branch_taken together with load_use -> pc_write=1, no stall, all three flushes=1.
- reset asserted mid-DISCARD -> outputs 0 immediately, ctrl_state=0. With IFID_HAZARD_PERF_EN defined, the counters read 0.
